mem_issue_queue: RTL and testbench

In-order issue queue for load/store instructions, sitting between dispatch/rename and the AGU. It buffers renamed memory ops and tracks source-operand readiness through writeback wakeup broadcasts. It reads the physical register file and hands the oldest ready op to the AGU through a registered issue slot. It also assigns each store a sequence tag, and each op the tag of its youngest older store, for store-buffer ordering.

---
 rtl/mem_issue_queue.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_issue_queue.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_issue_queue.sv
// mem_issue_queue: in-order load/store issue queue between rename and the AGU.
// Buffers renamed memory ops in a circular FIFO, tracks source readiness from
// writeback broadcasts, reads the PRF for the head op and hands it to the AGU
// through a registered issue slot. Stores receive sequence tags; every op
// records the tag of its youngest older store.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   flush                      clears all queue state like reset
//   dispatch_*                 one renamed op per cycle, accepted when dispatch_ready
//   wb_valid / wb_phy_dest     per-port wakeup broadcasts
//   prf_raddr1/2, prf_rdata1/2 combinational PRF read of the head sources
//   issue_to_agu_valid, issue_inst, agu_allowin   registered issue slot handshake
//   queue_empty                no queued entries and slot empty

package mem_issue_queue_pkg;

   typedef enum logic [3:0] {
      OP_NOP = 4'd0,
      OP_LB  = 4'd1,
      OP_LH  = 4'd2,
      OP_LWL = 4'd3,
      OP_LW  = 4'd4,
      OP_LBU = 4'd5,
      OP_LHU = 4'd6,
      OP_LWR = 4'd7,
      OP_SB  = 4'd8,
      OP_SH  = 4'd9,
      OP_SWL = 4'd10,
      OP_SW  = 4'd11,
      OP_SWR = 4'd12
   } operation_t;

   typedef struct packed {
      operation_t  operation;
      logic [15:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
   } inst_t;

   typedef struct packed {
      inst_t       inst;
      logic [5:0]  phy_dest;
      logic [31:0] src1_value;
      logic [31:0] src2_value;
      logic [3:0]  rob_entry_num;
      logic [3:0]  store_num;
      logic [3:0]  pre_store;
   } issue_to_execute_bus_t;

   typedef struct packed {
      operation_t  op;
      logic [15:0] imm;
      logic [3:0]  rob;
      logic [5:0]  dest;
      logic [5:0]  src1;
      logic [5:0]  src2;
      logic        rdy1;
      logic        rdy2;
      logic [3:0]  store_num;
      logic [3:0]  pre_store;
   } mem_iq_entry_t;

endpackage

module mem_issue_queue
   import mem_issue_queue_pkg::*;
#(
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned WB_PORTS = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           flush,
   input  logic                           dispatch_valid,
   output logic                           dispatch_ready,
   input  operation_t                     dispatch_op,
   input  logic [15:0]                    dispatch_imm,
   input  logic [3:0]                     dispatch_rob_entry_num,
   input  logic [5:0]                     dispatch_phy_dest,
   input  logic [5:0]                     dispatch_phy_src1,
   input  logic [5:0]                     dispatch_phy_src2,
   input  logic                           dispatch_src1_ready,
   input  logic                           dispatch_src2_ready,
   input  logic [WB_PORTS-1:0]            wb_valid,
   input  logic [WB_PORTS-1:0][5:0]       wb_phy_dest,
   output logic [5:0]                     prf_raddr1,
   output logic [5:0]                     prf_raddr2,
   input  logic [31:0]                    prf_rdata1,
   input  logic [31:0]                    prf_rdata2,
   output logic                           issue_to_agu_valid,
   input  logic                           agu_allowin,
   output issue_to_execute_bus_t          issue_inst,
   output logic                           queue_empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   mem_iq_entry_t           ent_q [DEPTH];
   logic [DEPTH-1:0]        ent_valid;
   logic [PTR_W-1:0]        head;
   logic [PTR_W-1:0]        tail;
   logic [CNT_W-1:0]        count;
   logic [3:0]              store_ctr;

   logic [DEPTH-1:0]        wake1;
   logic [DEPTH-1:0]        wake2;
   mem_iq_entry_t           head_entry;
   mem_iq_entry_t           new_entry;
   issue_to_execute_bus_t   issue_next;
   logic                    is_store;
   logic                    dispatch_fire;
   logic                    eligible;
   logic                    move;

   // True when any valid broadcast port names physical register r.
   function automatic logic wb_hit(input logic [5:0]                r,
                                   input logic [WB_PORTS-1:0]       v,
                                   input logic [WB_PORTS-1:0][5:0]  d);
      logic hit;
      hit = 1'b0;
      for (int p = 0; p < int'(WB_PORTS); p++) begin
         hit = hit | (v[p] && (d[p] == r));
      end
      return hit;
   endfunction

   assign head_entry     = ent_q[head];
   assign prf_raddr1     = head_entry.src1;
   assign prf_raddr2     = head_entry.src2;
   assign dispatch_ready = (count != CNT_W'(DEPTH));
   assign queue_empty    = (count == '0) && !issue_to_agu_valid;
   assign dispatch_fire  = dispatch_valid && dispatch_ready;
   // Strictly in order: only the head may issue.
   assign eligible       = (count != '0) && head_entry.rdy1 && head_entry.rdy2;
   assign move           = eligible && (!issue_to_agu_valid || agu_allowin);

   // Wakeup matches for every stored entry.
   always_comb begin
      wake1 = '0;
      wake2 = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         wake1[i] = wb_hit(ent_q[i].src1, wb_valid, wb_phy_dest);
         wake2[i] = wb_hit(ent_q[i].src2, wb_valid, wb_phy_dest);
      end
   end

   // New entry, including same-cycle wakeup and store tagging.
   always_comb begin
      is_store = dispatch_op inside {OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR};
      new_entry           = '0;
      new_entry.op        = dispatch_op;
      new_entry.imm       = dispatch_imm;
      new_entry.rob       = dispatch_rob_entry_num;
      new_entry.dest      = dispatch_phy_dest;
      new_entry.src1      = dispatch_phy_src1;
      new_entry.src2      = dispatch_phy_src2;
      new_entry.rdy1      = dispatch_src1_ready || (dispatch_phy_src1 == 6'd0) ||
                            wb_hit(dispatch_phy_src1, wb_valid, wb_phy_dest);
      new_entry.rdy2      = dispatch_src2_ready || (dispatch_phy_src2 == 6'd0) ||
                            wb_hit(dispatch_phy_src2, wb_valid, wb_phy_dest);
      new_entry.pre_store = store_ctr;
      new_entry.store_num = is_store ? store_ctr + 4'd1 : store_ctr;
   end

   // Slot payload built from the head entry and the same-cycle PRF read.
   always_comb begin
      issue_next                = '0;
      issue_next.inst.operation = head_entry.op;
      issue_next.inst.imm       = head_entry.imm;
      issue_next.phy_dest       = head_entry.dest;
      issue_next.src1_value     = prf_rdata1;
      issue_next.src2_value     = prf_rdata2;
      issue_next.rob_entry_num  = head_entry.rob;
      issue_next.store_num      = head_entry.store_num;
      issue_next.pre_store      = head_entry.pre_store;
   end

   // Queue storage, pointers, store tagging and the issue slot.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         head               <= '0;
         tail               <= '0;
         count              <= '0;
         store_ctr          <= 4'd0;
         ent_valid          <= '0;
         issue_to_agu_valid <= 1'b0;
         issue_inst         <= '0;
      end else begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            if (ent_valid[i] && wake1[i]) ent_q[i].rdy1 <= 1'b1;
            if (ent_valid[i] && wake2[i]) ent_q[i].rdy2 <= 1'b1;
         end

         if (move) begin
            issue_inst         <= issue_next;
            issue_to_agu_valid <= 1'b1;
            ent_valid[head]    <= 1'b0;
            head               <= head + PTR_W'(1);
         end else if (agu_allowin) begin
            issue_to_agu_valid <= 1'b0;
         end

         // Tail never aliases a popping head: that needs a full queue.
         if (dispatch_fire) begin
            ent_q[tail]     <= new_entry;
            ent_valid[tail] <= 1'b1;
            tail            <= tail + PTR_W'(1);
            if (is_store) store_ctr <= store_ctr + 4'd1;
         end

         case ({dispatch_fire, move})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_issue_queue.sv
// tb_mem_issue_queue: directed scenarios followed by random traffic, checked
// cycle by cycle against an in-order queue model kept in the bench.
module tb_mem_issue_queue;
   import mem_issue_queue_pkg::*;

   localparam int unsigned DEPTH    = 8;
   localparam int unsigned WB_PORTS = 4;

   logic                       clk = 1'b0;
   logic                       reset, flush;
   logic                       dispatch_valid, dispatch_ready;
   operation_t                 dispatch_op;
   logic [15:0]                dispatch_imm;
   logic [3:0]                 dispatch_rob_entry_num;
   logic [5:0]                 dispatch_phy_dest, dispatch_phy_src1, dispatch_phy_src2;
   logic                       dispatch_src1_ready, dispatch_src2_ready;
   logic [WB_PORTS-1:0]        wb_valid;
   logic [WB_PORTS-1:0][5:0]   wb_phy_dest;
   logic [5:0]                 prf_raddr1, prf_raddr2;
   logic [31:0]                prf_rdata1, prf_rdata2;
   logic                       issue_to_agu_valid, agu_allowin, queue_empty;
   issue_to_execute_bus_t      issue_inst;

   mem_issue_queue #(.DEPTH(DEPTH), .WB_PORTS(WB_PORTS)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
      .dispatch_op(dispatch_op), .dispatch_imm(dispatch_imm),
      .dispatch_rob_entry_num(dispatch_rob_entry_num),
      .dispatch_phy_dest(dispatch_phy_dest),
      .dispatch_phy_src1(dispatch_phy_src1), .dispatch_phy_src2(dispatch_phy_src2),
      .dispatch_src1_ready(dispatch_src1_ready), .dispatch_src2_ready(dispatch_src2_ready),
      .wb_valid(wb_valid), .wb_phy_dest(wb_phy_dest),
      .prf_raddr1(prf_raddr1), .prf_raddr2(prf_raddr2),
      .prf_rdata1(prf_rdata1), .prf_rdata2(prf_rdata2),
      .issue_to_agu_valid(issue_to_agu_valid), .agu_allowin(agu_allowin),
      .issue_inst(issue_inst), .queue_empty(queue_empty)
   );

   always #5 clk = ~clk;

   // Physical register file model; p0 reads as zero.
   logic [31:0] prf [64];
   assign prf_rdata1 = prf[prf_raddr1];
   assign prf_rdata2 = prf[prf_raddr2];

   typedef struct {
      operation_t  op;
      logic [15:0] imm;
      logic [3:0]  rob;
      logic [5:0]  dest, s1, s2;
      bit          r1, r2;
      logic [3:0]  sn, ps;
   } mop_t;

   mop_t                  q[$];
   int                    m_sc = 0;
   bit                    m_slot_v = 0;
   bit                    m_moved = 0;
   issue_to_execute_bus_t m_bus = '0;
   logic [7:0]            cap[$];

   int checks = 0;
   int failures = 0;

   operation_t OPS [12] = '{OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR,
                            OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR};
   logic [7:0] EXP_TAG [4] = '{8'h10, 8'h11, 8'h21, 8'h22};

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit woken(input logic [5:0] r);
      for (int p = 0; p < int'(WB_PORTS); p++)
         if (wb_valid[p] && wb_phy_dest[p] == r) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit is_st(input operation_t op);
      return op inside {OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR};
   endfunction

   task automatic idle();
      reset = 1'b0; flush = 1'b0; dispatch_valid = 1'b0; wb_valid = '0;
   endtask

   task automatic disp(input operation_t op, input logic [5:0] s1, input bit r1,
                       input logic [5:0] s2, input bit r2, input logic [3:0] rob);
      dispatch_valid = 1'b1; dispatch_op = op;
      dispatch_imm = 16'($urandom); dispatch_phy_dest = 6'($urandom);
      dispatch_phy_src1 = s1; dispatch_src1_ready = r1;
      dispatch_phy_src2 = s2; dispatch_src2_ready = r2;
      dispatch_rob_entry_num = rob;
   endtask

   // One clock: check combinational outputs, advance the model, check the slot.
   task automatic step();
      int sz;
      mop_t h, n;
      issue_to_execute_bus_t b;
      chk("dispatch_ready", 128'(dispatch_ready), 128'(q.size() != int'(DEPTH)));
      chk("queue_empty", 128'(queue_empty), 128'(q.size() == 0 && !m_slot_v));
      if (q.size() > 0) begin
         chk("prf_raddr1", 128'(prf_raddr1), 128'(q[0].s1));
         chk("prf_raddr2", 128'(prf_raddr2), 128'(q[0].s2));
      end
      m_moved = 0;
      if (reset || flush) begin
         q.delete(); m_sc = 0; m_slot_v = 0; m_bus = '0;
      end else begin
         sz = q.size();
         if (sz > 0 && q[0].r1 && q[0].r2 && (!m_slot_v || agu_allowin)) begin
            h = q.pop_front();
            b = '0;
            b.inst.operation = h.op; b.inst.imm = h.imm; b.phy_dest = h.dest;
            b.src1_value = prf[h.s1]; b.src2_value = prf[h.s2];
            b.rob_entry_num = h.rob; b.store_num = h.sn; b.pre_store = h.ps;
            m_bus = b; m_slot_v = 1; m_moved = 1;
         end else if (agu_allowin) begin
            m_slot_v = 0;
         end
         foreach (q[i]) begin
            if (woken(q[i].s1)) q[i].r1 = 1;
            if (woken(q[i].s2)) q[i].r2 = 1;
         end
         if (dispatch_valid && sz < int'(DEPTH)) begin
            n.op = dispatch_op; n.imm = dispatch_imm; n.rob = dispatch_rob_entry_num;
            n.dest = dispatch_phy_dest; n.s1 = dispatch_phy_src1; n.s2 = dispatch_phy_src2;
            n.r1 = dispatch_src1_ready || dispatch_phy_src1 == 0 || woken(dispatch_phy_src1);
            n.r2 = dispatch_src2_ready || dispatch_phy_src2 == 0 || woken(dispatch_phy_src2);
            n.ps = 4'(m_sc);
            n.sn = is_st(dispatch_op) ? 4'(m_sc + 1) : 4'(m_sc);
            if (is_st(dispatch_op)) m_sc = (m_sc + 1) % 16;
            q.push_back(n);
         end
      end
      @(posedge clk);
      #1;
      for (int p = 0; p < int'(WB_PORTS); p++)
         if (wb_valid[p] && wb_phy_dest[p] != 0) prf[wb_phy_dest[p]] = $urandom;
      chk("issue_valid", 128'(issue_to_agu_valid), 128'(m_slot_v));
      if (m_slot_v) chk("issue_inst", 128'(issue_inst), 128'(m_bus));
      if (m_moved) cap.push_back({issue_inst.store_num, issue_inst.pre_store});
   endtask

   initial begin
      foreach (prf[i]) prf[i] = (i == 0) ? 32'd0 : $urandom;
      idle();
      agu_allowin = 1'b1;
      wb_phy_dest = '0;
      disp(OP_LW, 6'd0, 1'b1, 6'd0, 1'b1, 4'd0);
      dispatch_valid = 1'b0;

      // Reset
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_dispatch_ready", 128'(dispatch_ready), 128'(1));
      chk("rst_issue_valid", 128'(issue_to_agu_valid), 128'(0));
      chk("rst_issue_inst", 128'(issue_inst), 128'(0));
      chk("rst_queue_empty", 128'(queue_empty), 128'(1));

      // LW latency and operand read
      prf[5] = 32'h1000;
      disp(OP_LW, 6'd5, 1'b1, 6'd0, 1'b0, 4'd3);
      dispatch_imm = 16'h1234;
      step();
      idle();
      chk("lw_valid_c1", 128'(issue_to_agu_valid), 128'(0));
      step();
      chk("lw_valid_c2", 128'(issue_to_agu_valid), 128'(1));
      chk("lw_src1", 128'(issue_inst.src1_value), 128'(32'h1000));
      chk("lw_imm", 128'(issue_inst.inst.imm), 128'(16'h1234));
      step();
      chk("lw_empty", 128'(queue_empty), 128'(1));

      // Store tagging
      flush = 1'b1; step(); idle(); cap.delete();
      disp(OP_SW, 6'd0, 1'b1, 6'd0, 1'b1, 4'd0); step();
      disp(OP_LB, 6'd0, 1'b1, 6'd0, 1'b1, 4'd1); step();
      disp(OP_SB, 6'd0, 1'b1, 6'd0, 1'b1, 4'd2); step();
      disp(OP_LW, 6'd0, 1'b1, 6'd0, 1'b1, 4'd3); step();
      idle(); repeat (3) step();
      chk("tag_count", 128'(cap.size()), 128'(4));
      for (int i = 0; i < cap.size() && i < 4; i++) chk("tag_seq", 128'(cap[i]), 128'(EXP_TAG[i]));

      // Store tag wrap
      flush = 1'b1; step(); idle(); cap.delete();
      for (int i = 0; i < 17; i++) begin
         disp(OP_SW, 6'd0, 1'b1, 6'd0, 1'b1, 4'(i)); step();
      end
      idle(); repeat (3) step();
      chk("wrap_count", 128'(cap.size()), 128'(17));
      if (cap.size() == 17) chk("wrap_17th", 128'(cap[16]), 128'(8'h10));

      // Fill, wake head, accept ninth; blocked head holds a ready younger op
      flush = 1'b1; step(); idle();
      for (int i = 0; i < 8; i++) begin
         disp(OP_LW, 6'(20 + i), 1'b0, 6'd0, 1'b1, 4'(i)); step();
      end
      idle();
      chk("full_ready", 128'(dispatch_ready), 128'(0));
      wb_valid = 4'b0001; wb_phy_dest[0] = 6'd20; step();
      idle(); step();
      chk("pop_ready", 128'(dispatch_ready), 128'(1));
      chk("pop_rob", 128'(issue_inst.rob_entry_num), 128'(0));
      disp(OP_LW, 6'd0, 1'b1, 6'd0, 1'b1, 4'd8); step();
      idle(); repeat (3) step();
      chk("blocked_head", 128'(issue_to_agu_valid), 128'(0));
      wb_valid = 4'b1000; wb_phy_dest[3] = 6'd21; step();
      idle(); step();
      chk("woken_head_rob", 128'(issue_inst.rob_entry_num), 128'(1));

      // AGU stall then release
      flush = 1'b1; step(); idle();
      for (int i = 0; i < 3; i++) begin
         disp(OP_LH, 6'(1 + i), 1'b1, 6'(2 + i), 1'b1, 4'(i)); step();
      end
      idle(); agu_allowin = 1'b0;
      repeat (6) step();
      agu_allowin = 1'b1;
      repeat (4) step();

      // Flush with entries, a valid slot and a simultaneous dispatch
      for (int i = 0; i < 6; i++) begin
         disp(OP_SB, 6'd30, 1'b0, 6'd0, 1'b1, 4'(i)); step();
      end
      disp(OP_LW, 6'd0, 1'b1, 6'd0, 1'b1, 4'd1);
      idle(); wb_valid = 4'b0010; wb_phy_dest[1] = 6'd30; step();
      agu_allowin = 1'b0; step();
      disp(OP_SW, 6'd0, 1'b1, 6'd0, 1'b1, 4'd9); flush = 1'b1; step();
      idle(); agu_allowin = 1'b1;
      chk("flush_valid", 128'(issue_to_agu_valid), 128'(0));
      chk("flush_empty", 128'(queue_empty), 128'(1));
      cap.delete();
      disp(OP_SW, 6'd0, 1'b1, 6'd0, 1'b1, 4'd2); step();
      idle(); repeat (2) step();
      chk("flush_store_ctr", 128'(cap.size() == 1 ? cap[0] : 8'hff), 128'(8'h10));

      // Random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         reset = 1'b0;
         flush = ($urandom_range(0, 59) == 0);
         disp(OPS[$urandom_range(0, 11)], 6'($urandom_range(0, 15)), $urandom_range(0, 2) == 0,
              6'($urandom_range(0, 15)), $urandom_range(0, 2) == 0, 4'($urandom));
         dispatch_valid = ($urandom_range(0, 2) != 0);
         for (int p = 0; p < int'(WB_PORTS); p++) begin
            wb_valid[p] = ($urandom_range(0, 2) == 0);
            wb_phy_dest[p] = 6'($urandom_range(0, 15));
         end
         agu_allowin = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
